uart_rx_core: RTL
=================

# uart_rx_core

Serial receiver for the UART peripheral. It is the receive-side partner of the transmitter that drives the CPU's `tx` pin. It deserialises the asynchronous `rx` line (8N1, LSB first) using 16x oversampling, holds one received byte for the Peripheral register file and flags framing and overrun errors. It sits between the `rx` pad and the Peripheral's UART data/status registers and supplies the receive-interrupt source.

## Interface

**Parameters**

- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `DIV`, default `CLK_FREQ/(BAUD*16)` (integer, truncated): clock cycles per oversample tick. Must be ≥ 1.

**Ports** (clock and reset first)

- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `rx` in 1: serial line, asynchronous, idle high.
- `rd_ack` in 1: one-cycle pulse from the Peripheral when it reads the data register; consumes the byte and clears the errors.
- `rx_data` out 8: last accepted byte.
- `rx_valid` out 1: `rx_data` holds an unconsumed byte.
- `frame_err` out 1: sticky; the stop bit was sampled low.
- `overrun` out 1: sticky; a byte completed while `rx_valid` = 1.
- `irq` out 1: one-cycle pulse when a byte is loaded into `rx_data`.

## Operation

- **Synchroniser**
  - `rx` passes through 2 flops; both reset to 1.
  - All decisions use the second flop, `rxs`.
- **Tick generator**
  - Counter 0..DIV-1; emits `tick` when the count equals DIV-1.
  - Held at 0 in IDLE, so tick phase is aligned to the start edge.
- **Sample counter**
  - 4 bits, counts ticks and wraps 15 → 0.
  - Mid-bit sample is taken on the tick where the count equals 7.
- **Bit counter**: 3 bits, indexes data bits 0..7.
- **State machine**
  - IDLE: `rxs` = 0 → START, with tick and sample counters cleared.
  - START: at mid-sample, `rxs` = 1 → IDLE (false start, no flags); `rxs` = 0 → DATA, bit counter = 0.
  - DATA: at each mid-sample, shift `rxs` into bit[bit counter] (LSB first). After bit 7 → STOP; otherwise increment.
  - STOP: at mid-sample → IDLE, with the outcome below.
- **STOP outcome**
  - `rxs` = 1 and `rx_valid` = 0 (or `rd_ack` in the same cycle): load `rx_data`, set `rx_valid`, pulse `irq`.
  - `rxs` = 1 and `rx_valid` = 1 with no `rd_ack`: the byte is dropped, `overrun` is set, `rx_data` is unchanged, no `irq`.
  - `rxs` = 0: the byte is dropped, `frame_err` is set, no `irq`. The FSM still returns to IDLE and waits for `rxs` = 1 before a new start can be detected; a low line is not a new start.
- **rd_ack**
  - Clears `rx_valid`, `frame_err` and `overrun`.
  - When it coincides with a load, the load wins for `rx_valid` (stays 1) and the error flags still clear.
  - `rd_ack` while `rx_valid` = 0 only clears the flags.
- Returning to IDLE at mid-stop gives half a bit of margin for the next start edge.

## Timing

- **Reset values**: `rx_data` = 0x00, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, `irq` = 0, FSM in IDLE, all counters 0.
- **Reset mid-frame**: the frame is abandoned immediately. After release, a new frame is received only on a fresh falling edge.
- **One bit** = 16·DIV cycles.
- **Start detection**: 2 cycles after the `rx` falling edge, because of the synchroniser.
- **Latency**: from the `rx` falling edge of the start bit to `rx_valid` rising = 2 + (9·16 + 8)·DIV cycles, ±1 cycle.
- **Outputs**: `rx_valid` and `irq` assert in the same cycle.
- **Flag persistence**: `rx_valid`, `frame_err` and `overrun` hold until `rd_ack` or reset.
- **Glitch rejection**: a low pulse shorter than 8·DIV cycles is rejected as a false start.

## Test plan

All scenarios use `CLK_FREQ` = 1_600_000 and `BAUD` = 100_000, so DIV = 1 and one bit = 16 cycles.

- **Single byte**: send 0xA5 with a valid stop → `rx_data` = 0xA5, `rx_valid` = 1 and `irq` high for 1 cycle at 154 ±1 cycles after the start edge. Then pulse `rd_ack` → `rx_valid` = 0.
- **Glitch**: `rx` low for 4 cycles, then high → no state change beyond START→IDLE, `rx_valid`, `frame_err` and `irq` stay 0. A following 0x3C is then received correctly.
- **Framing error**: send 0x55 with the stop bit 0 → `frame_err` = 1, `rx_valid` = 0, no `irq`. Hold the line low for 40 cycles → no new byte. Release high and send 0x12 → `rx_data` = 0x12, `frame_err` still 1 until `rd_ack`.
- **Overrun**: send 0x11 then 0x22 back-to-back with no `rd_ack` → `rx_data` = 0x11, `overrun` = 1. `rd_ack` → `rx_valid` = 0, `overrun` = 0.
- **Simultaneous ack/load**: with 0x11 pending, assert `rd_ack` in the exact mid-stop cycle of 0x99 → `rx_data` = 0x99, `rx_valid` = 1, `overrun` = 0, `irq` pulses.
- **Reset mid-frame**: assert `reset` low during data bit 4 of 0xF0, release 3 cycles later, hold `rx` high → all outputs at reset values. The next frame 0x0F is received as 0x0F.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with 16x oversampling.
// Deserialises the rx line LSB first, holds one byte for the register file,
// and reports framing and overrun errors. irq pulses when a byte is loaded.
module uart_rx_core #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       irq
);

    localparam int            TW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic            rx_meta_r;
    logic            rxs_r;
    logic [TW-1:0]   tick_cnt_r;
    logic [3:0]      samp_cnt_r;
    logic [2:0]      bit_cnt_r;
    logic [7:0]      shift_r;
    logic            wait_high_r;

    logic [7:0]      rx_data_r;
    logic            rx_valid_r;
    logic            frame_err_r;
    logic            overrun_r;
    logic            irq_r;

    logic            tick_s;
    logic            mid_s;
    logic            load_s;
    logic            ovr_set_s;
    logic            ferr_set_s;
    logic            shift_en_s;
    logic            bit_clr_s;
    logic            bit_inc_s;

    assign tick_s = (tick_cnt_r == TICK_LAST);
    assign mid_s  = tick_s && (samp_cnt_r == 4'd7);

    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign irq       = irq_r;

    // Two-flop synchroniser for the asynchronous rx line; idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rxs_r     <= rx_meta_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and per-cycle control strobes.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        ovr_set_s   = 1'b0;
        ferr_set_s  = 1'b0;
        shift_en_s  = 1'b0;
        bit_clr_s   = 1'b0;
        bit_inc_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                // After a framing error a still-low line is not a new start.
                if (!rxs_r && !wait_high_r) begin
                    state_nxt_s = S_START;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_START: begin
                if (mid_s) begin
                    if (rxs_r) begin
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_DATA;
                        bit_clr_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = S_START;
                end
            end
            S_DATA: begin
                if (mid_s) begin
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s = S_STOP;
                    end else begin
                        bit_inc_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            S_STOP: begin
                if (mid_s) begin
                    // Leaving at mid-stop leaves half a bit to catch the next start edge.
                    state_nxt_s = S_IDLE;
                    if (rxs_r) begin
                        if (!rx_valid_r || rd_ack) begin
                            load_s = 1'b1;
                        end else begin
                            ovr_set_s = 1'b1;
                        end
                    end else begin
                        ferr_set_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = S_STOP;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Oversample tick divider and sample counter; both parked at zero in IDLE
    // so sampling phase is referenced to the detected start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_r <= {TW{1'b0}};
            samp_cnt_r <= 4'd0;
        end else if (state_r == S_IDLE) begin
            tick_cnt_r <= {TW{1'b0}};
            samp_cnt_r <= 4'd0;
        end else if (tick_s) begin
            tick_cnt_r <= {TW{1'b0}};
            samp_cnt_r <= samp_cnt_r + 4'd1;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
            samp_cnt_r <= samp_cnt_r;
        end
    end

    // Bit index and data shift register, LSB first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            if (bit_clr_s) begin
                bit_cnt_r <= 3'd0;
            end else if (bit_inc_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (shift_en_s) begin
                shift_r[bit_cnt_r] <= rxs_r;
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    // Blocks start detection after a framing error until the line returns high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_high_r <= 1'b0;
        end else if (ferr_set_s) begin
            wait_high_r <= 1'b1;
        end else if (rxs_r) begin
            wait_high_r <= 1'b0;
        end else begin
            wait_high_r <= wait_high_r;
        end
    end

    // Received byte holding register, status flags and receive interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            irq_r <= load_s;
            if (load_s) begin
                rx_data_r <= shift_r;
            end else begin
                rx_data_r <= rx_data_r;
            end
            // A load in the same cycle as an ack keeps the byte valid.
            if (load_s) begin
                rx_valid_r <= 1'b1;
            end else if (rd_ack) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
            // A fresh error event takes priority over a coincident ack.
            if (ferr_set_s) begin
                frame_err_r <= 1'b1;
            end else if (rd_ack) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (rd_ack) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

endmodule
